// File: rtl/decode_stage.sv
// decode_stage: one-deep RV32I decode stage with valid/ready handshakes and RUN/HALT/TRAP control.
// Build option: define DECODE_ILLEGAL_TRAP_EN to flag illegal instructions and stop in TRAP.
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 4
`endif

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [XLEN-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [4:0]                    rd,
    output logic                          reg_write,
    output logic                          mem_write,
    output logic                          alu_src,
    output logic                          mem2reg,
    output logic [`ALU_CONTROL_SIZE-1:0]  alu_control,
    output logic [XLEN-1:0]               imm,
    output logic [XLEN-1:0]               pc,
    output logic                          finish,
    output logic                          illegal,
    output logic [CNT_W-1:0]              dec_count
);

    localparam int ALU_W = `ALU_CONTROL_SIZE;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [ALU_W-1:0] ALU_ADD    = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB    = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL    = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT    = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR    = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL    = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA    = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR     = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND    = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_PASS_B = ALU_W'(10);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HALT = 2'd1;
    localparam logic [1:0] TRAP = 2'd2;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             reg_write;
        logic             mem_write;
        logic             alu_src;
        logic             mem2reg;
        logic [ALU_W-1:0] alu_control;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic             finish;
        logic             illegal;
    } bundle_t;

    logic [1:0]       state;
    logic             valid_q;
    bundle_t          bundle_q;
    logic [CNT_W-1:0] count_q;

    bundle_t          dec;
    logic             dec_bad;
    logic             accept;
    logic             drain;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Signed casts replicate instr[31] up to XLEN for every format.
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

    function automatic logic [ALU_W-1:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_of = ALU_SLL;
            3'd2:    alu_of = ALU_SLT;
            3'd3:    alu_of = ALU_SLTU;
            3'd4:    alu_of = ALU_XOR;
            3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: every decoded field is defaulted first so no path through the case can infer a latch.
        dec     = '0;
        dec_bad = 1'b0;
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.rd  = in_instr[11:7];
        dec.pc  = in_pc;
        case (opcode)
            OP_LOAD: begin
                dec_bad         = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                dec.reg_write   = 1'b1;
                dec.mem2reg     = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_i;
            end
            OP_STORE: begin
                dec_bad         = funct3[2] || (funct3[1:0] == 2'b11);
                dec.mem_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_s;
            end
            OP_IMM: begin
                // Only the shift-immediates constrain the upper bits; SRAI is selected by instr[30].
                dec_bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                          ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = alu_of(funct3, (funct3 == 3'd5) && in_instr[30]);
                dec.imm         = imm_i;
            end
            OP_REG: begin
                dec_bad = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
                dec.reg_write   = 1'b1;
                dec.alu_control = alu_of(funct3, in_instr[30]);
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_PASS_B;
                dec.imm         = imm_u;
            end
            OP_AUIPC: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_u;
            end
            OP_BRANCH: begin
                dec_bad = (funct3[2:1] == 2'b01);
                dec.imm = imm_b;
                if (!funct3[2])
                    dec.alu_control = ALU_SUB;
                else if (!funct3[1])
                    dec.alu_control = ALU_SLT;
                else
                    dec.alu_control = ALU_SLTU;
            end
            OP_JAL: begin
                dec.reg_write   = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_j;
            end
            OP_JALR: begin
                dec_bad         = (funct3 != 3'd0);
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_i;
            end
            OP_SYSTEM: begin
                if (in_instr[31:7] == 25'd0)
                    dec.finish = 1'b1;
                else
                    dec_bad = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
        // An illegal word leaves a NOP bundle; only the flag differs between builds.
        if (dec_bad) begin
            dec.reg_write   = 1'b0;
            dec.mem_write   = 1'b0;
            dec.alu_src     = 1'b0;
            dec.mem2reg     = 1'b0;
            dec.alu_control = '0;
            dec.imm         = '0;
            dec.finish      = 1'b0;
            dec.illegal     = TRAP_EN;
        end
    end

    assign in_ready = (state == RUN) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state    <= RUN;
            valid_q  <= 1'b0;
            bundle_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                bundle_q <= dec;
                valid_q  <= 1'b1;
                if (dec.finish)
                    state <= HALT;
                else if (TRAP_EN && dec_bad)
                    state <= TRAP;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (drain)
                count_q <= count_q + CNT_W'(1);
        end
    end

    assign out_valid   = valid_q;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;
    assign rd          = bundle_q.rd;
    assign reg_write   = bundle_q.reg_write;
    assign mem_write   = bundle_q.mem_write;
    assign alu_src     = bundle_q.alu_src;
    assign mem2reg     = bundle_q.mem2reg;
    assign alu_control = bundle_q.alu_control;
    assign imm         = bundle_q.imm;
    assign pc          = bundle_q.pc;
    assign finish      = bundle_q.finish;
    assign illegal     = bundle_q.illegal;
    assign dec_count   = count_q;

endmodule
